// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: drives the Program_counter (pc_src/pc_in) and runs the
// instruction-memory fetch handshake, registering fetched words for decode.
// Control priority within a cycle: trap > redirect > halt > stall > sequential.
//
// Handshake: imem_req high asks for the word at imem_addr (= pc_curr); the
// transfer completes in a cycle where imem_req and imem_ack are both high, and
// while waiting imem_addr is held stable. instr_valid is a one-cycle strobe
// that decode must consume; stall suppresses the request so nothing is
// delivered while decode is not ready.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0010
) (
    input  logic        sysclk,
    input  logic        sysreset,
    input  logic [31:0] pc_curr,
    output logic        pc_src,
    output logic [31:0] pc_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        trap,
    input  logic        halt,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   accept;

    assign imem_addr = pc_curr;
    assign dbg_state = state;

    // State register; reset always lands in BOOT so the PC gets reloaded.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and PC control; the default in every state is to hold the PC.
    always_comb begin
        state_nxt = state;
        pc_src    = 1'b1;
        pc_in     = pc_curr;
        imem_req  = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_BOOT: begin
                pc_in     = RESET_VEC;
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = !stall && !halt;
                if (trap) begin
                    pc_in     = TRAP_VEC;
                    state_nxt = ST_FLUSH;
                end else if (branch_taken) begin
                    pc_in     = branch_target;
                    state_nxt = ST_FLUSH;
                end else if (halt) begin
                    state_nxt = ST_HALT;
                end else if (stall) begin
                    // hold; an ack arriving now is not accepted
                end else if (imem_ack) begin
                    pc_src = 1'b0;
                    accept = 1'b1;
                end
            end
            ST_FLUSH: begin
                // a trap here still wins; a redirect here is dropped
                if (trap) begin
                    pc_in = TRAP_VEC;
                end
                state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                if (trap) begin
                    pc_in     = TRAP_VEC;
                    state_nxt = ST_FLUSH;
                end else if (!halt) begin
                    state_nxt = ST_FETCH;
                end
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

    // Instruction output register: captures the accepted word and its address.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            instr_valid <= 1'b0;
            instr_data  <= 32'h0;
            instr_pc    <= 32'h0;
        end else begin
            instr_valid <= accept;
            if (accept) begin
                instr_data <= imem_data;
                instr_pc   <= pc_curr;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: owns a Program_counter stand-in, runs directed
// scenarios with literal expectations, then randomized traffic against a
// behavioural model of the sequencing rules.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RST_V  = 32'h0000_0100;
    localparam logic [31:0] TRAP_V = 32'h0000_0010;

    logic        sysclk;
    logic        sysreset;
    logic [31:0] pc_reg;
    logic        pc_src;
    logic [31:0] pc_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        trap;
    logic        halt;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: which special cycle comes next, and the expected deliveries
    bit          m_boot   = 1'b1;
    bit          m_flush  = 1'b0;
    bit          m_frozen = 1'b0;
    bit          rst_prev = 1'b0;
    logic [63:0] exp_q[$];

    pc_fetch_sequencer #(.RESET_VEC(RST_V), .TRAP_VEC(TRAP_V)) dut (
        .sysclk        (sysclk),
        .sysreset      (sysreset),
        .pc_curr       (pc_reg),
        .pc_src        (pc_src),
        .pc_in         (pc_in),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .trap          (trap),
        .halt          (halt),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .dbg_state     (dbg_state)
    );

    // clock
    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    // Program_counter stand-in: load pc_in or increment with 32-bit wrap
    always @(posedge sysclk) begin
        if (sysreset) pc_reg <= 32'h0;
        else if (pc_src) pc_reg <= pc_in;
        else pc_reg <= pc_reg + 32'd1;
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endfunction

    // Per-cycle model comparison, sampled at the falling edge.
    task automatic compare();
        bit          e_src;
        logic [31:0] e_in;
        bit          e_req;
        bit          take;
        logic [63:0] e;
        if (sysreset) begin
            if (rst_prev) begin
                chk("rst_valid", {31'd0, instr_valid}, 32'd0);
                chk("rst_data", instr_data, 32'd0);
                chk("rst_pc", instr_pc, 32'd0);
            end
            m_boot = 1'b1; m_flush = 1'b0; m_frozen = 1'b0;
            exp_q.delete();
            rst_prev = 1'b1;
            return;
        end
        rst_prev = 1'b0;
        // delivery: exactly the word accepted in the previous cycle, if any
        chk("valid", {31'd0, instr_valid}, {31'd0, exp_q.size() != 0});
        if (instr_valid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("instr_pc", instr_pc, e[63:32]);
            chk("instr_data", instr_data, e[31:0]);
        end
        exp_q.delete();
        // PC control rules
        e_src = 1'b1; e_in = pc_reg; e_req = 1'b0; take = 1'b0;
        if (m_boot) begin
            e_in = RST_V; m_boot = 1'b0;
        end else if (m_flush) begin
            if (trap) e_in = TRAP_V;
            m_flush = 1'b0;
        end else if (m_frozen) begin
            if (trap) begin e_in = TRAP_V; m_frozen = 1'b0; m_flush = 1'b1; end
            else if (!halt) m_frozen = 1'b0;
        end else begin
            e_req = !stall && !halt;
            if (trap) begin e_in = TRAP_V; m_flush = 1'b1; end
            else if (branch_taken) begin e_in = branch_target; m_flush = 1'b1; end
            else if (halt) m_frozen = 1'b1;
            else if (!stall && imem_ack) begin e_src = 1'b0; take = 1'b1; end
        end
        chk("pc_src", {31'd0, pc_src}, {31'd0, e_src});
        if (e_src) chk("pc_in", pc_in, e_in);
        chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
        chk("imem_addr", imem_addr, pc_reg);
        if (take) exp_q.push_back({pc_reg, imem_data});
    endtask

    task automatic tick();
        @(negedge sysclk);
        compare();
        @(posedge sysclk);
        #1;
    endtask

    task automatic peek();
        #1;
    endtask

    task automatic idle();
        stall = 0; halt = 0; branch_taken = 0; trap = 0; imem_ack = 0;
    endtask

    initial begin
        int halt_left;
        sysreset = 1; idle(); imem_data = 0; branch_target = 0;
        tick(); tick();
        chk("lit_reset_valid", {31'd0, instr_valid}, 32'd0);
        chk("lit_reset_pc", instr_pc, 32'd0);
        sysreset = 0; peek();
        chk("lit_boot_pc_in", pc_in, 32'h100);
        chk("lit_boot_req", {31'd0, imem_req}, 32'd0);
        tick();
        // three wait cycles, address held
        for (int i = 0; i < 3; i++) begin
            peek();
            chk("lit_wait_addr", imem_addr, 32'h100);
            chk("lit_wait_req", {31'd0, imem_req}, 32'd1);
            tick();
        end
        imem_ack = 1; imem_data = 32'hA5A5_0001; tick();
        chk("lit_first_valid", {31'd0, instr_valid}, 32'd1);
        chk("lit_first_pc", instr_pc, 32'h100);
        chk("lit_pc_after", pc_reg, 32'h101);
        // zero-wait stream
        for (int k = 0; k < 3; k++) begin
            imem_data = 32'hC000_0000 + k; tick();
            chk("lit_stream_pc", instr_pc, 32'h101 + k);
        end
        // redirect with an ack in the same cycle
        branch_taken = 1; branch_target = 32'h40; imem_data = 32'hDEAD_BEEF; tick();
        branch_taken = 0; peek();
        chk("lit_flush_valid", {31'd0, instr_valid}, 32'd0);
        chk("lit_flush_req", {31'd0, imem_req}, 32'd0);
        tick();
        peek();
        chk("lit_redir_addr", imem_addr, 32'h40);
        // trap and redirect together
        trap = 1; branch_taken = 1; branch_target = 32'h80; tick();
        trap = 0; branch_taken = 0; imem_ack = 0; tick();
        imem_ack = 1; imem_data = 32'h1234_5678; tick();
        chk("lit_trap_pc", instr_pc, 32'h10);
        chk("lit_trap_data", instr_data, 32'h1234_5678);
        // stall for four cycles
        stall = 1;
        for (int i = 0; i < 4; i++) begin
            peek();
            chk("lit_stall_req", {31'd0, imem_req}, 32'd0);
            tick();
            chk("lit_stall_valid", {31'd0, instr_valid}, 32'd0);
            chk("lit_stall_pc", pc_reg, 32'h11);
        end
        stall = 0; imem_data = 32'h5555_AAAA; tick();
        chk("lit_resume_pc", instr_pc, 32'h11);
        // halt five cycles, then a trap while halted
        imem_ack = 0; halt = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("lit_halt_pc", pc_reg, 32'h12);
        trap = 1; tick();
        trap = 0; halt = 0;
        chk("lit_halt_trap_pc", pc_reg, 32'h10);
        tick();
        peek();
        chk("lit_post_trap_req", {31'd0, imem_req}, 32'd1);
        // reset in the middle of a memory wait
        tick();
        sysreset = 1; tick();
        chk("lit_midrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("lit_midrst_req", {31'd0, imem_req}, 32'd0);
        sysreset = 0; tick();
        // PC wraparound through the last address
        branch_taken = 1; branch_target = 32'hFFFF_FFFF; tick();
        branch_taken = 0; tick();
        imem_ack = 1; imem_data = 32'h0BAD_F00D; tick();
        chk("lit_wrap_ipc", instr_pc, 32'hFFFF_FFFF);
        chk("lit_wrap_pc", pc_reg, 32'h0);
        // randomized traffic
        halt_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (halt_left == 0 && $urandom_range(0, 39) == 0) halt_left = $urandom_range(1, 6);
            halt = (halt_left != 0);
            if (halt_left != 0) halt_left--;
            stall         = ($urandom_range(0, 6) == 0);
            imem_ack      = ($urandom_range(0, 9) < 6);
            imem_data     = $urandom;
            branch_taken  = ($urandom_range(0, 11) == 0);
            branch_target = $urandom;
            trap          = ($urandom_range(0, 24) == 0);
            sysreset      = ($urandom_range(0, 299) == 0);
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
